rs_issue_sched: RTL and testbench
=================================

RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

Interface
REQ-001 SHALL have parameter NUM_RS_ENTRIES, default 8, meaning number of rs_entry instances scheduled; legal values 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port nuke_rb1  input  t_nuke_pkt  pipeline flush; only .valid is used.
REQ-005 SHALL have port disp_valid_rs0  input  1  dispatch offers one uop this cycle.
REQ-006 SHALL have port rs_full_rs0  output  1  no free entry; dispatch must hold.
REQ-007 SHALL have port e_alloc_rs0  output  NUM_RS_ENTRIES  one-hot allocate strobe per entry.
REQ-008 SHALL have port e_valid  input  NUM_RS_ENTRIES  per-entry occupied flag.
REQ-009 SHALL have port e_req_issue_rs1  input  NUM_RS_ENTRIES  per-entry issue request.
REQ-010 SHALL have port e_gnt_issue_rs1  output  NUM_RS_ENTRIES  one-hot-or-zero issue grant.
REQ-011 SHALL have port ex_stall_rs1  input  1  execute cannot accept a uop this cycle.
REQ-012 SHALL have ports iss_valid_rs1 (output, 1) and iss_idx_rs1 (output, clog2(NUM_RS_ENTRIES)): a grant was issued and the index of the granted entry.

Function
REQ-013 SHALL allocate: e_alloc_rs0 = one-hot of lowest-index entry with e_valid==0, only when disp_valid_rs0 & ~rs_full_rs0 & ~nuke_rb1.valid; else all zero.
REQ-014 SHALL keep a registered occupancy counter occ (width clog2(NUM_RS_ENTRIES)+1): +1 on alloc, -1 on grant, unchanged when both occur, forced 0 on nuke_rb1.valid.
REQ-015 SHALL drive rs_full_rs0 = (occ == NUM_RS_ENTRIES), combinational from the register.
REQ-016 SHALL NOT reallocate an entry granted this cycle until the following cycle (the free set is ~e_valid only).
REQ-017 SHALL grant exactly one requesting entry per cycle when e_req_issue_rs1 != 0, ~ex_stall_rs1 and ~nuke_rb1.valid; otherwise e_gnt_issue_rs1 = 0.
REQ-018 SHALL select the oldest requester (see REQ-026); grant is combinational from the current-cycle request (zero latency).
REQ-019 SHALL drive iss_valid_rs1 = |e_gnt_issue_rs1 and iss_idx_rs1 = encoded grant index (0 when no grant).
REQ-020 SHALL maintain an age matrix age[i][j] (1 = entry i older than j): on alloc of k, set age[j][k]=1 for every valid j and clear row k.
REQ-021 SHALL clear the whole age matrix on nuke_rb1.valid; nuke takes priority over same-cycle alloc and grant.
REQ-022 SHALL flag an assertion (under ASSERT) when occ != popcount(e_valid), when e_gnt_issue_rs1 is not one-hot-or-zero, or when a grant targets a non-requesting entry.

Reset
REQ-023 SHALL, while reset is high, drive occ=0, age matrix=0, e_alloc_rs0=0, e_gnt_issue_rs1=0, iss_valid_rs1=0, iss_idx_rs1=0, rs_full_rs0=0.
REQ-024 SHALL, on reset asserted mid-operation, discard all in-flight state at the next edge with no grant or alloc issued during reset cycles.
REQ-025 SHALL resume normal alloc/grant the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, with RS_AGE_PICK_EN defined, pick requester i where no other requester j has age[j][i]=1; without it, pick the lowest-index requester and compile out the age matrix (REQ-020/021 void).

Structure
REQ-027 SHALL place NUM_RS_ENTRIES default, index width localparam and t_rs_age_row typedef in common.pkg; t_nuke_pkt stays in rob_defs.pkg.
REQ-028 SHALL implement the age matrix and oldest-pick as one sub-module rs_age_matrix, instantiated only under RS_AGE_PICK_EN.

Verification
REQ-029 Fill: 8 consecutive dispatches from reset -> alloc one-hots 0x01..0x80 in order, rs_full_rs0=1 after the 8th, 9th held.
REQ-030 Age: alloc entries 0,1,2, issue entry 1, alloc again (gets 1), all request -> grants 0,2,1 in order with RS_AGE_PICK_EN; 0,1,2 without.
REQ-031 Stall: requests 0x05 with ex_stall_rs1=1 for 3 cycles -> zero grants; on release grant 0x01, iss_idx_rs1=0.
REQ-032 Full+issue: full RS, grant entry 3 and disp_valid_rs0 same cycle -> no alloc that cycle, occ stays 8->7, alloc 0x08 next cycle.
REQ-033 Nuke: 5 valid entries, nuke_rb1.valid with disp and requests -> no grant, no alloc, occ=0, age matrix 0 next cycle.
REQ-034 Reset mid-run: reset asserted with 4 valid entries -> all outputs 0 during reset, first dispatch after reset allocates 0x01.

Source files
------------

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared reservation-station sizing and age-row types
package common_pkg;

  localparam int RS_NUM_ENTRIES = 8;
  localparam int RS_IDX_W       = $clog2(RS_NUM_ENTRIES);

  typedef logic [RS_NUM_ENTRIES-1:0] t_rs_age_row;

endpackage

// File: rtl/rob_defs_pkg.sv
// rtl/rob_defs_pkg.sv - reorder-buffer side types seen by the RS
package rob_defs_pkg;

  typedef struct packed {
    logic       valid;
    logic [5:0] rob_id;
  } t_nuke_pkt;

endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - age matrix and oldest-requester pick, used only with RS_AGE_PICK_EN
module rs_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] req,
  output logic [N-1:0] pick
);

  // age[i][j] = 1 means entry i was allocated before entry j
  logic [N-1:0] age [N];
  logic         found;
  logic         older;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < N; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (alloc[i])
            age[i][j] <= 1'b0;
          else if (alloc[j] && valid[i])
            age[i][j] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    older = 1'b0;
    for (int i = 0; i < N; i++) begin
      older = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && age[j][i]) older = 1'b1;
      end
      if (req[i] && !older && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - RS allocate/issue scheduler; RS_AGE_PICK_EN selects oldest-first issue
module rs_issue_sched
  import common_pkg::*, rob_defs_pkg::*;
#(
  parameter int NUM_RS_ENTRIES = RS_NUM_ENTRIES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  t_nuke_pkt                         nuke_rb1,
  input  logic                              disp_valid_rs0,
  output logic                              rs_full_rs0,
  output logic [NUM_RS_ENTRIES-1:0]         e_alloc_rs0,
  input  logic [NUM_RS_ENTRIES-1:0]         e_valid,
  input  logic [NUM_RS_ENTRIES-1:0]         e_req_issue_rs1,
  output logic [NUM_RS_ENTRIES-1:0]         e_gnt_issue_rs1,
  input  logic                              ex_stall_rs1,
  output logic                              iss_valid_rs1,
  output logic [$clog2(NUM_RS_ENTRIES)-1:0] iss_idx_rs1
);

  localparam int IDX_W = (NUM_RS_ENTRIES == RS_NUM_ENTRIES) ? RS_IDX_W : $clog2(NUM_RS_ENTRIES);
  localparam int OCC_W = IDX_W + 1;

  logic [OCC_W-1:0]          occ;
  logic                      nuke;
  logic                      full_q;
  logic [NUM_RS_ENTRIES-1:0] free_vec;
  logic [NUM_RS_ENTRIES-1:0] alloc_pick;
  logic [NUM_RS_ENTRIES-1:0] gnt_pick;
  logic                      unused_nuke;

  assign nuke        = nuke_rb1.valid;
  assign unused_nuke = ^nuke_rb1.rob_id;
  assign full_q      = (occ == OCC_W'(NUM_RS_ENTRIES));
  assign rs_full_rs0 = ~reset & full_q;

  // An entry granted this cycle still shows e_valid, so it cannot be reused until next cycle
  assign free_vec   = ~e_valid;
  assign alloc_pick = free_vec & (~free_vec + (NUM_RS_ENTRIES)'(1));
  assign e_alloc_rs0 = (~reset & disp_valid_rs0 & ~full_q & ~nuke) ? alloc_pick : '0;

`ifdef RS_AGE_PICK_EN
  rs_age_matrix #(
    .N(NUM_RS_ENTRIES)
  ) u_age (
    .clk   (clk),
    .reset (reset),
    .flush (nuke),
    .alloc (e_alloc_rs0),
    .valid (e_valid),
    .req   (e_req_issue_rs1),
    .pick  (gnt_pick)
  );
`else
  assign gnt_pick = e_req_issue_rs1 & (~e_req_issue_rs1 + (NUM_RS_ENTRIES)'(1));
`endif

  assign e_gnt_issue_rs1 = (~reset & ~ex_stall_rs1 & ~nuke & (|e_req_issue_rs1)) ? gnt_pick : '0;
  assign iss_valid_rs1   = |e_gnt_issue_rs1;

  always_comb begin
    iss_idx_rs1 = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (e_gnt_issue_rs1[i]) iss_idx_rs1 = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || nuke)
      occ <= '0;
    else if ((|e_alloc_rs0) && !iss_valid_rs1)
      occ <= occ + OCC_W'(1);
    else if (!(|e_alloc_rs0) && iss_valid_rs1)
      occ <= occ - OCC_W'(1);
  end

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (occ == OCC_W'($countones(e_valid)))
        else $error("rs_issue_sched: occupancy disagrees with e_valid");
      assert ($onehot0(e_gnt_issue_rs1))
        else $error("rs_issue_sched: multiple grants");
      assert ((e_gnt_issue_rs1 & ~e_req_issue_rs1) == '0)
        else $error("rs_issue_sched: grant without request");
    end
  end
`endif

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - directed bench with an entry-level reference model for rs_issue_sched
module tb_rs_issue_sched;
  import rob_defs_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  t_nuke_pkt    nuke;
  logic         disp;
  logic         full;
  logic [N-1:0] alloc;
  logic [N-1:0] e_valid;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         stall;
  logic         iss_valid;
  logic [2:0]   iss_idx;

  int nchk  = 0;
  int nfail = 0;

  // Reference model: which entries hold a uop, and the order they were allocated in
  logic [N-1:0] mdl_valid = '0;
  int           stamp [N];
  int           seq = 0;
  logic [N-1:0] exp_alloc = '0;
  logic [N-1:0] exp_gnt = '0;
  logic         exp_full;

  assign e_valid = mdl_valid;

  always #5 clk = ~clk;

  rs_issue_sched #(.NUM_RS_ENTRIES(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .nuke_rb1        (nuke),
    .disp_valid_rs0  (disp),
    .rs_full_rs0     (full),
    .e_alloc_rs0     (alloc),
    .e_valid         (e_valid),
    .e_req_issue_rs1 (req),
    .e_gnt_issue_rs1 (gnt),
    .ex_stall_rs1    (stall),
    .iss_valid_rs1   (iss_valid),
    .iss_idx_rs1     (iss_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] lowest_free(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (!v[i]) return N'(1) << i;
    return '0;
  endfunction

  function automatic logic [N-1:0] pick_req(input logic [N-1:0] r);
    int best;
    best = -1;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
`ifdef RS_AGE_PICK_EN
        if (best < 0 || stamp[i] < stamp[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return (best < 0) ? '0 : (N'(1) << best);
  endfunction

  function automatic int index_of(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_full  = 1'b0;
      exp_alloc = '0;
      exp_gnt   = '0;
    end else begin
      exp_full  = ($countones(mdl_valid) == N);
      exp_alloc = (disp && !exp_full && !nuke.valid) ? lowest_free(mdl_valid) : '0;
      exp_gnt   = (req != '0 && !stall && !nuke.valid) ? pick_req(req) : '0;
    end
    chk("alloc", 32'(alloc), 32'(exp_alloc));
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("iss_valid", 32'(iss_valid), 32'(exp_gnt != '0));
    chk("iss_idx", 32'(iss_idx), 32'(index_of(exp_gnt)));
    chk("rs_full", 32'(full), 32'(exp_full));
  end

  always @(posedge clk) begin
    if (reset || nuke.valid) begin
      mdl_valid <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (exp_alloc[k]) begin
          mdl_valid[k] <= 1'b1;
          stamp[k]     <= seq;
        end
        if (exp_gnt[k]) mdl_valid[k] <= 1'b0;
      end
      if (exp_alloc != '0) seq <= seq + 1;
    end
  end

  task automatic set_in(input logic d, input logic [N-1:0] r, input logic st,
                        input logic nk, input logic rs);
    disp       = d;
    req        = r;
    stall      = st;
    nuke.valid = nk;
    reset      = rs;
  endtask

  task automatic to_mid();
    @(negedge clk);
    #1;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] age_exp [3];

  initial begin
    nuke.rob_id = 6'h15;
    set_in(1'b1, '0, 1'b0, 1'b0, 1'b1);

    // Reset holds everything quiet even with dispatch offered
    repeat (2) begin
      to_mid();
      chk("rst_alloc", 32'(alloc), 0);
      chk("rst_full", 32'(full), 0);
      to_next();
    end

    // Fill from empty, then the ninth dispatch must be held
    for (int i = 0; i < N; i++) begin
      set_in(1'b1, '0, 1'b0, 1'b0, 1'b0);
      to_mid();
      chk("fill_alloc", 32'(alloc), 32'(1) << i);
      to_next();
    end
    set_in(1'b1, '0, 1'b0, 1'b0, 1'b0);
    to_mid();
    chk("fill_full", 32'(full), 1);
    chk("fill_held", 32'(alloc), 0);
    to_next();

    // Full RS: issue entry 3 with dispatch; the freed slot is reused only next cycle
    set_in(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    to_mid();
    chk("fi_alloc", 32'(alloc), 0);
    chk("fi_gnt", 32'(gnt), 32'h08);
    chk("fi_idx", 32'(iss_idx), 3);
    to_next();
    set_in(1'b1, '0, 1'b0, 1'b0, 1'b0);
    to_mid();
    chk("fi_full", 32'(full), 0);
    chk("fi_realloc", 32'(alloc), 32'h08);
    to_next();

    // Drain to five entries, then nuke with dispatch and requests pending
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, N'(1) << i, 1'b0, 1'b0, 1'b0);
      to_next();
    end
    set_in(1'b1, 8'hF8, 1'b0, 1'b1, 1'b0);
    to_mid();
    chk("nk_gnt", 32'(gnt), 0);
    chk("nk_alloc", 32'(alloc), 0);
    to_next();

    // Age ordering: alloc 0,1,2; issue 1; realloc gets 1; then everyone requests
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, '0, 1'b0, 1'b0, 1'b0);
      to_mid();
      chk("nk_realloc", 32'(alloc), 32'(1) << i);
      to_next();
    end
    set_in(1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    to_next();
    set_in(1'b1, '0, 1'b0, 1'b0, 1'b0);
    to_mid();
    chk("age_realloc", 32'(alloc), 32'h02);
    to_next();
`ifdef RS_AGE_PICK_EN
    age_exp[0] = 8'h01; age_exp[1] = 8'h04; age_exp[2] = 8'h02;
`else
    age_exp[0] = 8'h01; age_exp[1] = 8'h02; age_exp[2] = 8'h04;
`endif
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, mdl_valid, 1'b0, 1'b0, 1'b0);
      to_mid();
      chk("age_order", 32'(gnt), 32'(age_exp[i]));
      to_next();
    end

    // Stall holds grants; release grants entry 0 while entry 3 is allocated
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, '0, 1'b0, 1'b0, 1'b0);
      to_next();
    end
    repeat (3) begin
      set_in(1'b0, 8'h05, 1'b1, 1'b0, 1'b0);
      to_mid();
      chk("stall_gnt", 32'(gnt), 0);
      chk("stall_iss", 32'(iss_valid), 0);
      to_next();
    end
    set_in(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    to_mid();
    chk("rel_gnt", 32'(gnt), 32'h01);
    chk("rel_idx", 32'(iss_idx), 0);
    chk("rel_alloc", 32'(alloc), 32'h08);
    to_next();

    // Reset mid-run with four valid entries
    set_in(1'b1, '0, 1'b0, 1'b0, 1'b0);
    to_next();
    repeat (2) begin
      set_in(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1);
      to_mid();
      chk("mrst_alloc", 32'(alloc), 0);
      chk("mrst_gnt", 32'(gnt), 0);
      chk("mrst_iss", 32'(iss_valid), 0);
      to_next();
    end
    set_in(1'b1, '0, 1'b0, 1'b0, 1'b0);
    to_mid();
    chk("post_rst_alloc", 32'(alloc), 32'h01);
    to_next();

    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) to_next();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
